// File: rtl/vision_pkg.sv
// Shared constants for the vision pipeline (gradient window buffer and harris stage).
package vision_pkg;
    localparam int num_bits_in  = 13;
    localparam int image_width  = 640;
    localparam int image_height = 480;
    localparam int win_size     = 3;
    localparam int win_elems    = win_size * win_size;

    function automatic int addr_bits(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction
endpackage

// File: rtl/line_buffer.sv
// Single-port line memory: combinational read of the old word, write of the new word at the same address.
module line_buffer
    import vision_pkg::*;
#(
    parameter int p_data_width = num_bits_in,
    parameter int p_depth      = image_width
)(
    input  logic                          clk,
    input  logic                          wr_en,
    input  logic [addr_bits(p_depth)-1:0] addr,
    input  logic [p_data_width-1:0]       wr_data,
    output logic [p_data_width-1:0]       rd_data
);
    logic [p_data_width-1:0] mem [p_depth];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[addr] <= wr_data;
        end
    end
endmodule

// File: rtl/gradient_window_buffer.sv
// Builds 3x3 Ix/Iy neighbourhoods from a raster gradient stream using two line buffers per channel.
module gradient_window_buffer
    import vision_pkg::*;
#(
    parameter int p_num_bits_in = num_bits_in,
    parameter int p_width       = image_width,
    parameter int p_height      = image_height
)(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic                       in_sof,
    input  logic [p_num_bits_in-1:0]   in_Ix,
    input  logic [p_num_bits_in-1:0]   in_Iy,
    output logic                       out_valid,
    output logic [9*p_num_bits_in-1:0] out_win_Ix,
    output logic [9*p_num_bits_in-1:0] out_win_Iy,
    output logic [9:0]                 out_x,
    output logic [8:0]                 out_y
);
    localparam int nb = p_num_bits_in;
    localparam int cw = addr_bits(p_width);
    localparam int rw = addr_bits(p_height);
    localparam logic [cw-1:0] last_col = cw'(p_width - 1);
    localparam logic [rw-1:0] last_row = rw'(p_height - 1);
    localparam logic [cw-1:0] col_two  = cw'(2);
    localparam logic [rw-1:0] row_two  = rw'(2);

    logic [cw-1:0] col, eff_col;
    logic [rw-1:0] row, eff_row;
    logic          accept, trigger;
    logic [nb-1:0] pix      [2];
    logic [nb-1:0] line1    [2];
    logic [nb-1:0] line2    [2];
    logic [nb-1:0] win      [2][win_elems];
    logic [nb-1:0] win_next [2][win_elems];

    assign pix[0] = in_Ix;
    assign pix[1] = in_Iy;

    // A start-of-frame pixel is placed at (0,0) whatever the counters say.
    always_comb begin
        accept  = in_valid && !reset;
        eff_col = in_sof ? '0 : col;
        eff_row = in_sof ? '0 : row;
        trigger = accept && (eff_row >= row_two) && (eff_col >= col_two);
    end

    for (genvar ch = 0; ch < 2; ch++) begin : g_chan
        line_buffer #(.p_data_width(nb), .p_depth(p_width)) u_line1 (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (eff_col),
            .wr_data (pix[ch]),
            .rd_data (line1[ch])
        );
        line_buffer #(.p_data_width(nb), .p_depth(p_width)) u_line2 (
            .clk     (clk),
            .wr_en   (accept),
            .addr    (eff_col),
            .wr_data (line1[ch]),
            .rd_data (line2[ch])
        );
    end

    always_comb begin
        for (int ch = 0; ch < 2; ch++) begin
            for (int r = 0; r < 3; r++) begin
                win_next[ch][r*3]   = win[ch][r*3+1];
                win_next[ch][r*3+1] = win[ch][r*3+2];
            end
            win_next[ch][2] = line2[ch];
            win_next[ch][5] = line1[ch];
            win_next[ch][8] = pix[ch];
        end
    end

    // Outputs are loaded only on a window-producing pixel so they hold between windows.
    always_ff @(posedge clk) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            out_win_Ix <= '0;
            out_win_Iy <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                for (int k = 0; k < win_elems; k++) begin
                    win[ch][k] <= '0;
                end
            end
        end else begin
            out_valid <= trigger;
            if (accept) begin
                win <= win_next;
                if (eff_col == last_col) begin
                    col <= '0;
                    row <= (eff_row == last_row) ? '0 : eff_row + rw'(1);
                end else begin
                    col <= eff_col + cw'(1);
                    row <= eff_row;
                end
            end
            if (trigger) begin
                out_x <= 10'(eff_col) - 10'd1;
                out_y <= 9'(eff_row) - 9'd1;
                for (int k = 0; k < win_elems; k++) begin
                    out_win_Ix[k*nb +: nb] <= win_next[0][k];
                    out_win_Iy[k*nb +: nb] <= win_next[1][k];
                end
            end
        end
    end
endmodule

// File: tb/tb_gradient_window_buffer.sv
// Scoreboard bench for gradient_window_buffer on a 5x4 image; expected windows come from a frame-image model.
module tb_gradient_window_buffer;
    localparam int nb = 13;
    localparam int w  = 5;
    localparam int h  = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_sof;
    logic [nb-1:0]    in_Ix;
    logic [nb-1:0]    in_Iy;
    logic             out_valid;
    logic [9*nb-1:0]  out_win_Ix;
    logic [9*nb-1:0]  out_win_Iy;
    logic [9:0]       out_x;
    logic [8:0]       out_y;

    typedef struct {
        logic [9*nb-1:0] ix;
        logic [9*nb-1:0] iy;
        int              x;
        int              y;
        int              edge_no;
    } exp_t;

    exp_t          sb[$];
    int            errors = 0;
    int            checks = 0;
    int            edges = 0;
    int            popped = 0;
    int            model_pos = 0;
    logic [nb-1:0] img_ix [h][w];
    logic [nb-1:0] img_iy [h][w];

    gradient_window_buffer #(.p_num_bits_in(nb), .p_width(w), .p_height(h)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_Ix      (in_Ix),
        .in_Iy      (in_Iy),
        .out_valid  (out_valid),
        .out_win_Ix (out_win_Ix),
        .out_win_Iy (out_win_Iy),
        .out_x      (out_x),
        .out_y      (out_y)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edges <= edges + 1;

    task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // The model places each pixel into a frame image by its raster position and cuts the 3x3 neighbourhood.
    task automatic modelPixel(input logic [nb-1:0] ix, input logic [nb-1:0] iy, input logic sof);
        int   r;
        int   c;
        exp_t e;
        if (sof) model_pos = 0;
        r = model_pos / w;
        c = model_pos % w;
        img_ix[r][c] = ix;
        img_iy[r][c] = iy;
        if (r >= 2 && c >= 2) begin
            for (int dr = 0; dr < 3; dr++) begin
                for (int dc = 0; dc < 3; dc++) begin
                    e.ix[(dr*3+dc)*nb +: nb] = img_ix[r-2+dr][c-2+dc];
                    e.iy[(dr*3+dc)*nb +: nb] = img_iy[r-2+dr][c-2+dc];
                end
            end
            e.x       = c - 1;
            e.y       = r - 1;
            e.edge_no = edges + 1;
            sb.push_back(e);
        end
        model_pos = (model_pos + 1) % (w * h);
    endtask

    task automatic applyStimulus(input logic [nb-1:0] ix, input logic [nb-1:0] iy, input logic sof);
        in_valid = 1'b1;
        in_sof   = sof;
        in_Ix    = ix;
        in_Iy    = iy;
        modelPixel(ix, iy, sof);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'($urandom_range(1, 0));
        in_Ix    = nb'($urandom);
        in_Iy    = nb'($urandom);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sendFrame(input int start_idx, input int gap_max, input bit rand_vals);
        logic [nb-1:0] v;
        logic [nb-1:0] nv;
        for (int i = 0; i < w * h; i++) begin
            if (gap_max > 0) idle($urandom_range(gap_max, 0));
            v  = rand_vals ? nb'($urandom) : nb'(start_idx + i);
            nv = -v;
            applyStimulus(v, nv, i == 0);
        end
    endtask

    task automatic checkSegment(input string name, input int base, input int expected);
        idle(3);
        checkOutput(name, popped - base, expected);
        checkOutput({name, "_drained"}, sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_valid: got valid at x=%0d y=%0d expected no window", out_x, out_y);
            end else begin
                e = sb.pop_front();
                popped++;
                checkOutput("win_ix", out_win_Ix, e.ix);
                checkOutput("win_iy", out_win_Iy, e.iy);
                checkOutput("out_x", out_x, e.x);
                checkOutput("out_y", out_y, e.y);
                checkOutput("valid_edge", edges, e.edge_no);
            end
        end
    end

    initial begin
        int            base;
        logic [nb-1:0] v;
        logic [nb-1:0] nv;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_Ix    = '0;
        in_Iy    = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_valid", out_valid, 0);
        checkOutput("reset_x", out_x, 0);
        checkOutput("reset_y", out_y, 0);
        checkOutput("reset_win_ix", out_win_Ix, 0);
        checkOutput("reset_win_iy", out_win_Iy, 0);
        reset = 1'b0;

        base = popped;
        sendFrame(0, 0, 1'b0);
        checkSegment("continuous_frame", base, 6);

        base = popped;
        sendFrame(0, 5, 1'b0);
        checkSegment("gapped_frame", base, 6);

        base = popped;
        sendFrame(0, 0, 1'b0);
        sendFrame(0, 0, 1'b0);
        checkSegment("back_to_back", base, 12);

        base = popped;
        for (int i = 0; i < 8; i++) begin
            v  = nb'(i);
            nv = -v;
            applyStimulus(v, nv, i == 0);
        end
        sendFrame(8, 0, 1'b0);
        checkSegment("midframe_sof", base, 6);

        base = popped;
        sendFrame(0, 3, 1'b1);
        checkSegment("random_values", base, 6);

        base = popped;
        for (int i = 0; i < 14; i++) begin
            v  = nb'(i);
            nv = -v;
            applyStimulus(v, nv, i == 0);
        end
        reset    = 1'b1;
        in_valid = 1'b1;
        in_sof   = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midrun_reset_valid", out_valid, 0);
        checkOutput("midrun_reset_x", out_x, 0);
        checkOutput("midrun_reset_win", out_win_Ix, 0);
        reset     = 1'b0;
        in_valid  = 1'b0;
        in_sof    = 1'b0;
        model_pos = 0;
        sendFrame(0, 0, 1'b0);
        checkSegment("after_reset", base, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/gradient_window_buffer.md
GRADIENT_WINDOW_BUFFER -- requirements
Module: gradient_window_buffer

Interface
REQ-001 Parameter p_num_bits_in, default 13, is the signed width of each Ix and Iy sample.
REQ-002 Parameter p_width, default 640, is the image width in pixels (minimum 3).
REQ-003 Parameter p_height, default 480, is the image height in lines (minimum 3).
REQ-004 Port clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 Port reset  input  1  is the synchronous, active-high reset.
REQ-006 Port in_valid  input  1  marks a gradient pixel presented this cycle.
REQ-007 Port in_sof  input  1  marks the first pixel of a frame; it is qualified by in_valid.
REQ-008 Port in_Ix  input  p_num_bits_in  is the signed horizontal gradient sample.
REQ-009 Port in_Iy  input  p_num_bits_in  is the signed vertical gradient sample.
REQ-010 Port out_valid  output  1  marks a complete 3x3 window on the outputs.
REQ-011 Port out_win_Ix  output  9*p_num_bits_in  is the packed Ix window; element r*3+c (row r, column c) occupies bits [(r*3+c+1)*p_num_bits_in-1 : (r*3+c)*p_num_bits_in].
REQ-012 Port out_win_Iy  output  9*p_num_bits_in  is the packed Iy window, using the same packing.
REQ-013 Port out_x  output  10  is the window-centre column.
REQ-014 Port out_y  output  9  is the window-centre row.

Function
REQ-015 The block is a raster-order stream consumer and has no backpressure: every cycle with in_valid=1 accepts one pixel.
REQ-016 Column counter col runs 0..p_width-1; row counter row runs 0..p_height-1; both advance only on accepted pixels.
REQ-017 On col=p_width-1, col wraps to 0 and row increments; on the last pixel of the frame, both wrap to 0.
REQ-018 An accepted pixel with in_sof=1 is treated as (row 0, col 0), regardless of the current counter values.
REQ-019 Each channel uses two line buffers of depth p_width, read-before-write at address col, so that lines row-1 and row-2 are available.
REQ-020 Each channel uses a 3x3 shift register: each accepted pixel shifts the columns left, and new column 2 = {line row-2, line row-1, incoming pixel}.
REQ-021 Window element (0,0) is the oldest row and column; element (2,2) is the newest accepted pixel.
REQ-022 out_valid is registered and rises exactly 1 cycle after an accepted pixel with row>=2 and col>=2; otherwise it is 0.
REQ-023 While out_valid=1, out_x=col-1 and out_y=row-1 of the triggering pixel.
REQ-024 Border pixels produce no window, so each frame yields exactly (p_width-2)*(p_height-2) valid windows.
REQ-025 out_win_*, out_x and out_y hold their values when out_valid=0; only out_valid is qualifying.
REQ-026 Gaps in in_valid of any length do not alter the window contents or the counters.
REQ-027 After a mid-frame in_sof, stale line-buffer data is never emitted, because validity is gated solely by the new row and col.
REQ-028 Samples are passed through bit-exact, with no arithmetic, sign change or saturation.

Reset
REQ-029 On reset=1: col=0, row=0, out_valid=0, window registers=0, out_win_*=0, out_x=0 and out_y=0 at the next edge.
REQ-030 Line-buffer memory contents are not reset.
REQ-031 Reset takes priority over in_valid and in_sof in the same cycle.

Structure
REQ-032 Constants p_num_bits_in, default p_width and default p_height reside in a shared package (vision_pkg) used by this block and by the harris stage.
REQ-033 One sub-module, line_buffer (single-port, read-before-write, parameterised width and depth), is instantiated four times: 2 lines x 2 channels.

Verification (bench with p_width=5, p_height=4, in_Ix=pixel index 0..19, in_Iy=-index)
REQ-034 Continuous frame, sof on index 0 -> first out_valid the cycle after index 12; Ix window = 0,1,2,5,6,7,10,11,12; Iy window = negated values; out_x=1, out_y=1.
REQ-035 Same frame -> exactly 6 valid windows with centres (1,1),(2,1),(3,1),(1,2),(2,2),(3,2); no valid on border pixels.
REQ-036 Random 0-5 cycle in_valid gaps -> windows identical to REQ-034/035, each out_valid exactly 1 cycle after its triggering pixel.
REQ-037 Two back-to-back frames with no gap -> frame 2 produces no valid during its rows 0-1, and its first window follows its index 12 with the same values as REQ-034.
REQ-038 in_sof asserted at index 8 -> that pixel is counted as (0,0); next valid follows the 13th pixel after sof, with out_x=1, out_y=1.
REQ-039 reset pulsed after index 13 -> out_valid=0 next cycle; a subsequent sof frame reproduces REQ-034 exactly.
